edid_ctrl: RTL and testbench

EDID_CTRL -- requirements
Module: edid_ctrl

---
 rtl/edid_pkg.sv | 30 +++
 rtl/edid_hpd_timer.sv | 34 +++
 rtl/edid_ctrl.sv | 166 ++++++++++++++++
 tb/tb_edid_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/edid_pkg.sv
// Shared EDID controller types: FSM state encoding, block geometry and checksum helper.
// The CSUM state exists only when EDID_CHKSUM_EN is defined.
package edid_pkg;

`ifdef EDID_CHKSUM_EN
   typedef enum logic [2:0] {
      ST_HOLD_LOW  = 3'd0,
      ST_READY     = 3'd1,
      ST_WAIT_IDLE = 3'd2,
      ST_UPDATE    = 3'd3,
      ST_CSUM      = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_HOLD_LOW  = 3'd0,
      ST_READY     = 3'd1,
      ST_WAIT_IDLE = 3'd2,
      ST_UPDATE    = 3'd3
   } state_t;
`endif

   localparam int         EDID_BLK_LEN = 128;
   localparam logic [6:0] CSUM_POS     = 7'd127;

   // Byte that makes the 128-byte block sum to zero modulo 256.
   function automatic logic [7:0] csum_byte(input logic [7:0] sum);
      return 8'd0 - sum;
   endfunction

endpackage

// File: rtl/edid_hpd_timer.sv
// HPD low-time counter: counts while en_i is high, clears whenever en_i drops.
// done_o rises combinationally in the CYC-th enabled cycle; the count saturates there.
module edid_hpd_timer #(
   parameter int unsigned CYC = 2700000
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic done_o
);

   localparam int unsigned W    = (CYC > 1) ? $clog2(CYC) : 1;
   localparam logic [W-1:0] LAST = W'(CYC - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign done_o = en_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (!en_i)
         cnt_d = '0;
      else if (!done_o)
         cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/edid_ctrl.sv
// EDID RAM controller: DDC-priority arbiter (ack 2 cycles after sampling, one access in flight) and HPD/update FSM.
// Define EDID_CHKSUM_EN to add the CSUM state that rewrites bytes 127 and 255 after each update.
module edid_ctrl
   import edid_pkg::*;
#(
   parameter int unsigned HPD_LOW_CYC = 2700000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ddc_req,
   input  logic [7:0] ddc_addr,
   input  logic       ddc_busy,
   output logic       ddc_ack,
   output logic [7:0] ddc_rdata,
   input  logic       cpu_req,
   input  logic       cpu_we,
   input  logic [7:0] cpu_addr,
   input  logic [7:0] cpu_wdata,
   output logic       cpu_ack,
   output logic       cpu_err,
   output logic [7:0] cpu_rdata,
   input  logic       upd_begin,
   input  logic       upd_end,
   output logic       upd_active,
   output logic       hpd_out,
   output logic       ram_en,
   output logic       ram_we,
   output logic [7:0] ram_addr,
   output logic [7:0] ram_wdata,
   input  logic [7:0] ram_rdata
);

   state_t     state_q;
   logic       hpd_q, tmr_done;
   logic       s1_q, s2_q;
   logic       g_cpu_q, g_mem_q, g_we_q, g_err_q;
   logic [7:0] g_addr_q, g_wdata_q;
   logic       cpu_ok, accept, arb_ram_en;

   edid_hpd_timer #(.CYC(HPD_LOW_CYC)) u_hpd_timer (
      .clk    (clk),
      .rst    (rst),
      .en_i   (state_q == ST_HOLD_LOW),
      .done_o (tmr_done)
   );

`ifdef EDID_CHKSUM_EN
   logic [7:0] cs_addr_q, sum_q, rd_add;
   logic       rd_vld_q, eng_en, eng_at_pos, eng_rd, eng_wr;

   assign cpu_ok     = cpu_req && (state_q != ST_CSUM);
   // The sweep yields to an arbiter access still in flight from UPDATE.
   assign eng_en     = (state_q == ST_CSUM) && !arb_ram_en;
   assign eng_at_pos = (cs_addr_q[6:0] == CSUM_POS);
   assign eng_rd     = eng_en && !eng_at_pos;
   assign eng_wr     = eng_en && eng_at_pos && !rd_vld_q;
   assign rd_add     = rd_vld_q ? ram_rdata : 8'h00;

   assign ram_en    = arb_ram_en || eng_rd || eng_wr;
   assign ram_we    = eng_wr || (arb_ram_en && g_we_q);
   assign ram_addr  = (eng_rd || eng_wr) ? cs_addr_q : g_addr_q;
   assign ram_wdata = eng_wr ? csum_byte(sum_q) : g_wdata_q;
   assign upd_active = (state_q == ST_WAIT_IDLE) || (state_q == ST_UPDATE) || (state_q == ST_CSUM);
`else
   assign cpu_ok     = cpu_req;
   assign ram_en     = arb_ram_en;
   assign ram_we     = arb_ram_en && g_we_q;
   assign ram_addr   = g_addr_q;
   assign ram_wdata  = g_wdata_q;
   assign upd_active = (state_q == ST_WAIT_IDLE) || (state_q == ST_UPDATE);
`endif

   assign accept     = !s1_q && !s2_q && (ddc_req || cpu_ok);
   assign arb_ram_en = s1_q && g_mem_q;

   assign hpd_out   = hpd_q;
   assign ddc_ack   = s2_q && !g_cpu_q;
   assign ddc_rdata = ddc_ack ? (g_mem_q ? ram_rdata : 8'hFF) : 8'h00;
   assign cpu_ack   = s2_q && g_cpu_q;
   assign cpu_err   = cpu_ack && g_err_q;
   assign cpu_rdata = (cpu_ack && !g_we_q) ? ram_rdata : 8'h00;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         g_cpu_q   <= 1'b0;
         g_mem_q   <= 1'b0;
         g_we_q    <= 1'b0;
         g_err_q   <= 1'b0;
         g_addr_q  <= 8'h00;
         g_wdata_q <= 8'h00;
      end else begin
         s1_q <= accept;
         s2_q <= s1_q;
         if (accept) begin
            g_cpu_q <= !ddc_req;
            if (ddc_req) begin
               g_mem_q <= (state_q == ST_HOLD_LOW) || (state_q == ST_READY);
               g_we_q  <= 1'b0;
               g_err_q <= 1'b0;
               g_addr_q <= ddc_addr;
            end else begin
               g_mem_q   <= !cpu_we || (state_q == ST_UPDATE);
               g_we_q    <= cpu_we;
               g_err_q   <= cpu_we && (state_q != ST_UPDATE);
               g_addr_q  <= cpu_addr;
               g_wdata_q <= cpu_wdata;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_HOLD_LOW;
         hpd_q   <= 1'b0;
`ifdef EDID_CHKSUM_EN
         cs_addr_q <= 8'h00;
         sum_q     <= 8'h00;
         rd_vld_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_HOLD_LOW: if (tmr_done) begin
               state_q <= ST_READY;
               hpd_q   <= 1'b1;
            end
            ST_READY: if (upd_begin) begin
               state_q <= ST_WAIT_IDLE;
               hpd_q   <= 1'b0;
            end
            ST_WAIT_IDLE: if (!ddc_busy) state_q <= ST_UPDATE;
            ST_UPDATE: if (upd_end) begin
`ifdef EDID_CHKSUM_EN
               state_q   <= ST_CSUM;
               cs_addr_q <= 8'h00;
               sum_q     <= 8'h00;
               rd_vld_q  <= 1'b0;
`else
               state_q   <= ST_HOLD_LOW;
`endif
            end
`ifdef EDID_CHKSUM_EN
            // Reads are pipelined; at the checksum slot the last byte is folded in, then the write goes out.
            ST_CSUM: if (eng_en) begin
               if (!eng_at_pos) begin
                  sum_q     <= sum_q + rd_add;
                  rd_vld_q  <= 1'b1;
                  cs_addr_q <= cs_addr_q + 8'd1;
               end else if (rd_vld_q) begin
                  sum_q    <= sum_q + rd_add;
                  rd_vld_q <= 1'b0;
               end else begin
                  sum_q     <= 8'h00;
                  cs_addr_q <= cs_addr_q + 8'd1;
                  if (cs_addr_q == 8'hFF) state_q <= ST_HOLD_LOW;
               end
            end
`endif
            default: state_q <= ST_HOLD_LOW;
         endcase
      end
   end

endmodule

// File: tb/tb_edid_ctrl.sv
// Directed bench for edid_ctrl with a 1-cycle-latency RAM model; HPD_LOW_CYC shortened to 16.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_edid_ctrl;

   localparam int unsigned LOWC = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       ddc_req, ddc_busy, ddc_ack;
   logic [7:0] ddc_addr, ddc_rdata;
   logic       cpu_req, cpu_we, cpu_ack, cpu_err;
   logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic       upd_begin, upd_end, upd_active, hpd_out;
   logic       ram_en, ram_we;
   logic [7:0] ram_addr, ram_wdata, ram_rdata;

   logic [7:0] mem [0:255];

   int         n_chk = 0;
   int         n_fail = 0;
   int         lat, lowc, cyc, t_d, t_c, errs, acks;
   logic       err, en_seen, got, act_ack, c_err;
   logic [7:0] d, c_data;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata     <= mem[ram_addr];
      end
   end

   edid_ctrl #(.HPD_LOW_CYC(LOWC)) dut (
      .clk(clk), .rst(rst),
      .ddc_req(ddc_req), .ddc_addr(ddc_addr), .ddc_busy(ddc_busy),
      .ddc_ack(ddc_ack), .ddc_rdata(ddc_rdata),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
      .upd_begin(upd_begin), .upd_end(upd_end), .upd_active(upd_active), .hpd_out(hpd_out),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic ddc_rd(input logic [7:0] a, output int l, output logic [7:0] dat, output logic en);
      ddc_addr = a;
      ddc_req  = 1'b1;
      l = 0;
      en = 1'b0;
      do begin
         @(negedge clk);
         l++;
         if (ram_en) en = 1'b1;
      end while (!ddc_ack && l < 10);
      dat = ddc_rdata;
      ddc_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic cpu_op(input logic we, input logic [7:0] a, input logic [7:0] wd,
                         output int l, output logic e, output logic [7:0] dat);
      cpu_we    = we;
      cpu_addr  = a;
      cpu_wdata = wd;
      cpu_req   = 1'b1;
      l = 0;
      do begin
         @(negedge clk);
         l++;
      end while (!cpu_ack && l < 10);
      e   = cpu_err;
      dat = cpu_rdata;
      cpu_req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      mem[8] = 8'h4C;
      rst = 1'b1;
      ddc_req = 0; ddc_addr = 0; ddc_busy = 0;
      cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      upd_begin = 0; upd_end = 0;
      repeat (3) @(negedge clk);

      chk("rst_hpd", hpd_out, 0);
      chk("rst_ddc_ack", ddc_ack, 0);
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_cpu_err", cpu_err, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ddc_rdata", ddc_rdata, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_upd_active", upd_active, 0);

      rst = 1'b0;
      lowc = 0;
      while (!hpd_out && lowc < 100) begin
         lowc++;
         @(negedge clk);
      end
      chk("hpd_low_after_reset", lowc, LOWC);
      chk("hpd_high_ready", hpd_out, 1);

      ddc_rd(8'h08, lat, d, en_seen);
      chk("ddc_rd_latency", lat, 2);
      chk("ddc_rd_data", d, 8'h4C);
      chk("ddc_rd_ram_en", en_seen, 1);

      // DDC and CPU request together: DDC wins, CPU follows 3 cycles later.
      ddc_addr = 8'h10; ddc_req = 1'b1;
      cpu_addr = 8'h03; cpu_we = 1'b0; cpu_req = 1'b1;
      t_d = 0; t_c = 0; c_data = 0; c_err = 1'b1;
      for (int t = 1; t <= 12; t++) begin
         @(negedge clk);
         if (ddc_ack && t_d == 0) begin t_d = t; d = ddc_rdata; ddc_req = 1'b0; end
         if (cpu_ack && t_c == 0) begin t_c = t; c_data = cpu_rdata; c_err = cpu_err; cpu_req = 1'b0; end
      end
      chk("arb_ddc_ack_cycle", t_d, 2);
      chk("arb_ddc_data", d, 8'h10);
      chk("arb_cpu_ack_cycle", t_c, 5);
      chk("arb_cpu_data", c_data, 8'h03);
      chk("arb_cpu_err", c_err, 0);

      upd_end = 1'b1;
      @(negedge clk);
      upd_end = 1'b0;
      repeat (3) @(negedge clk);
      chk("upd_end_ignored_hpd", hpd_out, 1);
      chk("upd_end_ignored_active", upd_active, 0);

      cpu_op(1'b1, 8'h05, 8'hAA, lat, err, d);
      chk("cpu_wr_ready_latency", lat, 2);
      chk("cpu_wr_ready_err", err, 1);
      chk("cpu_wr_ready_ram", mem[5], 8'h05);

      // Reset while a DDC read is in flight: no ack may follow.
      ddc_addr = 8'h08; ddc_req = 1'b1;
      @(negedge clk);
      chk("midrst_ram_en", ram_en, 1);
      rst = 1'b1; ddc_req = 1'b0;
      acks = 0;
      repeat (4) begin
         @(negedge clk);
         if (ddc_ack) acks++;
      end
      chk("midrst_no_ack", acks, 0);
      chk("midrst_hpd", hpd_out, 0);
      rst = 1'b0;
      lowc = 0;
      while (!hpd_out && lowc < 100) begin
         lowc++;
         @(negedge clk);
      end
      chk("hpd_low_after_midrst", lowc, LOWC);

      upd_begin = 1'b1; ddc_busy = 1'b1;
      @(negedge clk);
      upd_begin = 1'b0;
      chk("upd_begin_hpd", hpd_out, 0);
      chk("upd_begin_active", upd_active, 1);
      cpu_op(1'b1, 8'h00, 8'h77, lat, err, d);
      chk("cpu_wr_wait_idle_err", err, 1);
      chk("cpu_wr_wait_idle_ram", mem[0], 8'h00);
      repeat (6) @(negedge clk);
      ddc_busy = 1'b0;
      @(negedge clk);

      ddc_rd(8'h08, lat, d, en_seen);
      chk("ddc_upd_latency", lat, 2);
      chk("ddc_upd_data", d, 8'hFF);
      chk("ddc_upd_no_ram", en_seen, 0);

      errs = 0;
      for (int i = 0; i < 127; i++) begin
         cpu_op(1'b1, 8'(i), 8'h01, lat, err, d);
         if (err || lat != 2) errs++;
      end
      chk("upd_writes_ok", errs, 0);
      chk("upd_write_ram0", mem[0], 8'h01);
      cpu_op(1'b0, 8'd126, 8'h00, lat, err, d);
      chk("upd_read_back", d, 8'h01);
      chk("upd_read_err", err, 0);

      upd_end = 1'b1;
      @(negedge clk);
      upd_end = 1'b0;
      cpu_addr = 8'd127; cpu_we = 1'b0; cpu_req = 1'b1;
      got = 1'b0; act_ack = 1'b1; lowc = 0; cyc = 0; c_data = 0;
      while (!hpd_out && cyc < 2000) begin
         if (!upd_active) lowc++;
         if (cpu_ack && !got) begin
            got = 1'b1; act_ack = upd_active; c_data = cpu_rdata; cpu_req = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      cpu_req = 1'b0;
      chk("post_upd_hpd_high", hpd_out, 1);
      chk("post_upd_low_min", (lowc >= int'(LOWC)), 1);
      chk("post_upd_cpu_acked", got, 1);
      chk("post_upd_cpu_ack_outside", act_ack, 0);
      chk("ram126_kept", mem[126], 8'h01);
`ifdef EDID_CHKSUM_EN
      chk("post_upd_cpu_rdata", c_data, 8'h81);
      chk("csum_blk0", mem[127], 8'h81);
      chk("csum_blk1", mem[255], 8'h3F);
`else
      chk("post_upd_cpu_rdata", c_data, 8'h7F);
      chk("no_csum_blk0", mem[127], 8'h7F);
      chk("no_csum_blk1", mem[255], 8'hFF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
